// File: rtl/mac_table_matcher_if.sv
// Stream, configuration and verdict signals of the MAC table matcher.
interface mac_table_matcher_if #(
    parameter int IDX_W = 2
);
    logic              clear;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [47:0]       cfg_mac;
    logic [47:0]       cfg_mask;
    logic              cfg_en;
    logic [31:0]       data_in;
    logic              data_valid;
    logic              sof;
    logic              eof;
    logic              data_ready;
    logic [31:0]       data_out;
    logic              data_out_valid;
    logic              eof_out;
    logic              match;
    logic [IDX_W-1:0]  match_idx;
    logic [1:0]        match_offset;
    logic              frame_done;

    modport master (
        output clear, cfg_we, cfg_addr, cfg_mac, cfg_mask, cfg_en,
        output data_in, data_valid, sof, eof,
        input  data_ready, data_out, data_out_valid, eof_out,
        input  match, match_idx, match_offset, frame_done
    );

    modport slave (
        input  clear, cfg_we, cfg_addr, cfg_mac, cfg_mask, cfg_en,
        input  data_in, data_valid, sof, eof,
        output data_ready, data_out, data_out_valid, eof_out,
        output match, match_idx, match_offset, frame_done
    );
endinterface

// File: rtl/mac_table_matcher.sv
// Multi-entry masked MAC matcher: three-stage word pipeline, four byte
// alignments searched per evaluation, first hit of each frame latched.
//
// state    | meaning
// S_IDLE   | waiting for sof, non-sof words dropped
// S_FRAME  | shifting frame words in, evaluating windows
// S_FLUSH  | three bubble shifts drain the pipeline
// S_REPORT | verdict final, frame_done pulses on exit
module mac_table_matcher #(
    parameter int NUM_ENTRIES  = 4,
    parameter int WINDOW_WORDS = 4,
    parameter int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input logic                clk,
    input logic                rst,
    mac_table_matcher_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH, S_REPORT} state_t;

    logic [47:0]      r_mac  [NUM_ENTRIES];
    logic [47:0]      r_mask [NUM_ENTRIES];
    logic             r_en   [NUM_ENTRIES];

    state_t           r_state;
    logic             r_ready;
    logic [31:0]      r_a1, r_a2, r_a3;
    logic             r_v1, r_v2, r_v3;
    logic             r_e1, r_e2, r_e3;
    logic [7:0]       r_cnt;
    logic [1:0]       r_flush;
    logic             r_shifted;
    logic             r_ev_valid;
    logic [IDX_W-1:0] r_ev_idx;
    logic [1:0]       r_ev_off;
    logic [31:0]      r_dout;
    logic             r_dov;
    logic             r_eof_out;
    logic             r_match;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_off;
    logic             r_done;

    logic             w_take;
    logic             w_shift;
    logic             w_eval;
    logic [47:0]      w_win [4];
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic [1:0]       w_hit_off;

    // Words enter the pipeline only inside a frame; FLUSH shifts bubbles.
    assign w_take  = bus.data_valid && r_ready &&
                     ((r_state == S_IDLE && bus.sof) || r_state == S_FRAME);
    assign w_shift = w_take || (r_state == S_FLUSH);
    assign w_eval  = r_shifted && r_v1 && r_v2 && r_v3 &&
                     (int'(r_cnt) <= WINDOW_WORDS);

    // Table write port; survives clear, only rst wipes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                r_mac[e]  <= '0;
                r_mask[e] <= '0;
                r_en[e]   <= 1'b0;
            end
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_ENTRIES)) begin
            r_mac[bus.cfg_addr]  <= bus.cfg_mac;
            r_mask[bus.cfg_addr] <= bus.cfg_mask;
            r_en[bus.cfg_addr]   <= bus.cfg_en;
        end
    end

    // Candidate 48-bit windows at byte offsets 0..3 of the oldest word.
    always_comb begin
        w_win[0] = {r_a2[15:0], r_a3};
        w_win[1] = {r_a2[23:0], r_a3[31:8]};
        w_win[2] = {r_a2, r_a3[31:16]};
        w_win[3] = {r_a1[7:0], r_a2, r_a3[31:24]};
    end

    // Priority search: reverse scan so the lowest entry, then offset, wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_off = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            for (int k = 3; k >= 0; k--) begin
                if (r_en[e] && (((w_win[k] ^ r_mac[e]) & r_mask[e]) == 48'd0)) begin
                    w_hit     = 1'b1;
                    w_hit_idx = IDX_W'(e);
                    w_hit_off = 2'(k);
                end
            end
        end
    end

    // Sequencer, pipeline shift, evaluation register and verdict latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;   r_ready <= 1'b1;
            r_a1 <= '0;          r_a2 <= '0;        r_a3 <= '0;
            r_v1 <= 1'b0;        r_v2 <= 1'b0;      r_v3 <= 1'b0;
            r_e1 <= 1'b0;        r_e2 <= 1'b0;      r_e3 <= 1'b0;
            r_cnt <= '0;         r_flush <= '0;     r_shifted <= 1'b0;
            r_ev_valid <= 1'b0;  r_ev_idx <= '0;    r_ev_off <= '0;
            r_dout <= '0;        r_dov <= 1'b0;     r_eof_out <= 1'b0;
            r_match <= 1'b0;     r_idx <= '0;       r_off <= '0;
            r_done <= 1'b0;
        end else if (bus.clear) begin
            r_state <= S_IDLE;   r_ready <= 1'b1;
            r_a1 <= '0;          r_a2 <= '0;        r_a3 <= '0;
            r_v1 <= 1'b0;        r_v2 <= 1'b0;      r_v3 <= 1'b0;
            r_e1 <= 1'b0;        r_e2 <= 1'b0;      r_e3 <= 1'b0;
            r_cnt <= '0;         r_flush <= '0;     r_shifted <= 1'b0;
            r_ev_valid <= 1'b0;  r_ev_idx <= '0;    r_ev_off <= '0;
            r_dout <= '0;        r_dov <= 1'b0;     r_eof_out <= 1'b0;
            r_match <= 1'b0;     r_idx <= '0;       r_off <= '0;
            r_done <= 1'b0;
        end else begin
            r_shifted  <= w_shift;
            r_ev_valid <= w_eval && w_hit;
            r_ev_idx   <= w_hit_idx;
            r_ev_off   <= w_hit_off;
            r_done     <= 1'b0;

            if (r_ev_valid && !r_match) begin
                r_match <= 1'b1;
                r_idx   <= r_ev_idx;
                r_off   <= r_ev_off;
            end

            if (w_shift) begin
                r_a1 <= w_take ? bus.data_in : 32'd0;
                r_v1 <= w_take;
                r_e1 <= w_take && bus.eof;
                r_a2 <= r_a1;  r_v2 <= r_v1;  r_e2 <= r_e1;
                r_a3 <= r_a2;  r_v3 <= r_v2;  r_e3 <= r_e2;
                r_dout    <= r_a3;
                r_dov     <= r_v3;
                r_eof_out <= r_v3 && r_e3;
            end else begin
                r_dov     <= 1'b0;
                r_eof_out <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_cnt      <= 8'd1;
                        r_match    <= 1'b0;
                        r_idx      <= '0;
                        r_off      <= '0;
                        r_ev_valid <= 1'b0;
                        r_flush    <= '0;
                        r_state    <= bus.eof ? S_FLUSH : S_FRAME;
                        r_ready    <= !bus.eof;
                    end
                end
                S_FRAME: begin
                    if (w_take) begin
                        r_cnt <= (r_cnt == 8'd255) ? r_cnt : r_cnt + 8'd1;
                        if (bus.eof) begin
                            r_flush <= '0;
                            r_state <= S_FLUSH;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_flush <= r_flush + 2'd1;
                    if (r_flush == 2'd2) r_state <= S_REPORT;
                end
                default: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_ready     = r_ready;
    assign bus.data_out       = r_dout;
    assign bus.data_out_valid = r_dov;
    assign bus.eof_out        = r_eof_out;
    assign bus.match          = r_match;
    assign bus.match_idx      = r_idx;
    assign bus.match_offset   = r_off;
    assign bus.frame_done     = r_done;
endmodule

// File: doc/mac_table_matcher.md
# mac_table_matcher

Parametrised multi-entry MAC address matcher for the sniffer datapath. It sits between the 32-bit frame word stream and the downstream capture logic. It holds a table of NUM_ENTRIES programmable MAC addresses with per-bit masks and searches each frame's leading words at all four byte alignments. The frame passes through unchanged with a fixed pipeline delay, and a per-frame verdict reports hit, entry index and byte offset.

## Interface
- NUM_ENTRIES, default 4: number of table entries, 1..16.
- WINDOW_WORDS, default 4: a comparison window qualifies only if its newest word has 1-based frame index ≤ WINDOW_WORDS. Legal range 3..255.
- IDX_W, default $clog2(NUM_ENTRIES) (minimum 1): width of the entry index.

Clock and reset:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.

Control:
- clear, in, 1: synchronous flush. Does not touch the table.

Configuration:
- cfg_we, in, 1: table write strobe.
- cfg_addr, in, IDX_W: entry to write. Writes with cfg_addr ≥ NUM_ENTRIES are ignored.
- cfg_mac, in, 48: address to store.
- cfg_mask, in, 48: 1 means the bit is compared.
- cfg_en, in, 1: entry enable.

Input stream:
- data_in, in, 32: frame word.
- data_valid, in, 1: word present.
- sof, in, 1: first word of frame. Qualified by data_valid.
- eof, in, 1: last word of frame. Qualified by data_valid.
- data_ready, out, 1: word accepted when data_valid && data_ready.

Output stream:
- data_out, out, 32: delayed frame word.
- data_out_valid, out, 1: data_out is valid.
- eof_out, out, 1: data_out is the frame's last word.

Verdict:
- match, out, 1: sticky hit for the current frame.
- match_idx, out, IDX_W: entry index of the first hit.
- match_offset, out, 2: byte offset of the first hit.
- frame_done, out, 1: one-cycle pulse when the verdict is final.

## Operation
- Pipeline: three 32-bit stages a1 (newest), a2, a3, each with a valid tag v1..v3. A shift happens on every accepted word, and on every FLUSH cycle (a bubble with v=0 enters a1). On a shift, data_out <= a3 and data_out_valid <= v3; eof_out follows the eof tag carried with each stage. On non-shift cycles data_out_valid = 0.
- Candidate windows, for offsets 0..3:
  - 0: {a2[15:0], a3[31:0]}
  - 1: {a2[23:0], a3[31:8]}
  - 2: {a2[31:0], a3[31:16]}
  - 3: {a1[7:0], a2[31:0], a3[31:24]}
- An entry hits at offset k if it is enabled and ((window_k ^ mac) & mask) == 0. If mask is 0, any window matches.
- Evaluation runs only on the cycle after a shift, and only when v1 && v2 && v3 and the a1 word index ≤ WINDOW_WORDS.
- Priority: lowest entry index first, then lowest offset.
- Only the first hit of a frame is latched into match/match_idx/match_offset. Later hits are ignored.
- FSM:
  - IDLE: data_ready=1. Words without sof are accepted and discarded. An accepted sof word enters the pipeline; match fields and the word counter clear; go to FRAME. If that word also carries eof, go directly to FLUSH.
  - FRAME: data_ready=1. Each accepted word shifts in and the counter increments, saturating at 255. An accepted eof goes to FLUSH. A sof inside FRAME is treated as an ordinary data word.
  - FLUSH: data_ready=0. Three bubble shifts, then go to REPORT.
  - REPORT: data_ready=0. frame_done=1 for one cycle, then IDLE. match fields hold until the next accepted sof.
- Table write: on a cycle with cfg_we, the entry takes the new value at the next edge and is used from the next evaluation onward, including mid-frame.
- clear (synchronous, beats every other input except rst):
  - stages, tags, data_out, data_out_valid, eof_out, match fields and frame_done go to 0;
  - FSM goes to IDLE;
  - a cfg_we in the same cycle is still performed.
- rst: same as clear, and additionally every table entry gets mac=0, mask=0, en=0.

## Timing
- Reset values: data_ready=1; data_out=0; data_out_valid=0; eof_out=0; match=0; match_idx=0; match_offset=0; frame_done=0.
- A word accepted at edge t reaches data_out after 3 further shifts. With continuous input, that is 3 cycles later.
- The last frame word appears on data_out at FLUSH cycle 3. frame_done follows in the next cycle.
- The completing window is evaluated in the cycle after its shift. match rises at the following edge, i.e. 2 cycles after the completing word is accepted.
- Frames shorter than 3 words produce no evaluation: frame_done with match=0.
- Frame-to-frame gap is at least 4 cycles of data_ready=0 (3 FLUSH + 1 REPORT).

## Test plan
- Entry 0 = 00:11:22:33:44:55, mask all-ones, en=1. Frame words 0x22334455, 0x00000011, 0xAAAAAAAA, 0xBBBBBBBB (eof). Expect match=1, idx=0, offset=0, match rising 2 cycles after word 3 is accepted, and frame_done 4 cycles after eof.
- Same MAC shifted by 3 bytes across three words, with entry 2 also matching it. Expect idx=0, offset=3. Then disable entry 0 and rerun: expect idx=2.
- MAC placed starting at word 5 with WINDOW_WORDS=4. Expect match=0 and the frame output bit-exact with eof_out on the last word.
- Mask 0xFFFFFF000000 on an OUI-only entry. A frame with the matching OUI and arbitrary NIC bytes gives match=1; a frame with a different OUI gives match=0.
- Two-word frame (sof, then eof): expect no hit, frame_done=1, data_ready low for exactly 4 cycles.
- Assert clear mid-FRAME after word 2. Outputs zero next cycle, FSM returns to IDLE, table retained, and a following frame matches normally. Then assert rst: all outputs take their reset values and the table is disabled.
